// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle between a producer (the multiplier
// side, master) and the binary-to-BCD converter (slave).
interface bin2bcd_seq_if #(
    parameter int DW_2 = 16,
    parameter int NDIG = 5
);
    logic                start;
    logic [DW_2-1:0]     bin_in;
    logic                busy;
    logic                valid;
    logic [4*NDIG-1:0]   bcd;
    logic                neg;

    modport master (
        output start, bin_in,
        input  busy, valid, bcd, neg
    );

    modport slave (
        input  start, bin_in,
        output busy, valid, bcd, neg
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-packed-BCD converter.
// A rising edge on start captures bin_in; one bit is shifted per clock,
// so a DW_2-bit value takes DW_2 iterations. bcd/neg hold the last result
// and update only on the edge that raises valid.
// Optional feature macro: SIGNED_IN_EN (two's-complement input, sign on neg).

// Per-digit shift-and-add-3 correction. Digits never carry into each other.
module bin2bcd_add3 (
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);
    assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;
endmodule

module bin2bcd_seq #(
    parameter int DW_2 = 16,
    parameter int NDIG = 5,
    parameter int CNTW = $clog2(DW_2) + 1
) (
    input  logic             clk,
    input  logic             rst,
    bin2bcd_seq_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] LAST_IT = CNTW'(DW_2 - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_start_d;
    logic [DW_2-1:0]       r_shreg;
    logic [4*NDIG-1:0]     r_scr;
    logic [CNTW-1:0]       r_cnt;
    logic [4*NDIG-1:0]     r_bcd;

    logic                  w_trig;
    logic                  w_last;
    logic                  w_busy;
    logic                  w_valid;
    logic [DW_2-1:0]       w_mag;
    logic [4*NDIG-1:0]     w_adj;
    logic [4*NDIG-1:0]     w_scr_nxt;

    // Only a rising edge of the start level requests a conversion.
    assign w_trig = bus.start & ~r_start_d;
    assign w_last = (r_cnt == LAST_IT);

`ifdef SIGNED_IN_EN
    logic r_sign;
    logic r_neg;
    logic w_sign_in;

    // Negating the most-negative value wraps to 2^(DW_2-1), which is the
    // exact magnitude when the shift register is read as unsigned.
    assign w_sign_in = bus.bin_in[DW_2-1];
    assign w_mag     = w_sign_in ? (~bus.bin_in + DW_2'(1)) : bus.bin_in;
    assign bus.neg   = r_neg;

    // Sign is latched at capture and published alongside the BCD result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_trig)
                r_sign <= w_sign_in;
            if (r_state == S_SHIFT && w_last)
                r_neg <= r_sign;
        end
    end
`else
    assign w_mag   = bus.bin_in;
    assign bus.neg = 1'b0;
`endif

    // Add-3 correction on every scratch digit in parallel.
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bin2bcd_add3 u_add3 (
            .i_dig (r_scr[4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    // Corrected scratch shifted left; shreg MSB enters, top bit falls off.
    assign w_scr_nxt = {w_adj[4*NDIG-2:0], r_shreg[DW_2-1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig)
                    w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (w_last)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_valid     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture, iterate, and publish the result on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d <= 1'b0;
            r_shreg   <= '0;
            r_scr     <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
        end else begin
            r_start_d <= bus.start;
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_shreg <= w_mag;
                        r_scr   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_scr   <= w_scr_nxt;
                    r_shreg <= {r_shreg[DW_2-2:0], 1'b0};
                    r_cnt   <= r_cnt + CNTW'(1);
                    if (w_last)
                        r_bcd <= w_scr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = w_busy;
    assign bus.valid = w_valid;
    assign bus.bcd   = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed table of conversions plus hand-written
// sequences for held start, mid-conversion retrigger and reset abort.
module tb_bin2bcd_seq;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    bin2bcd_seq_if #(.DW_2(16), .NDIG(5)) bus ();

    bin2bcd_seq #(.DW_2(16), .NDIG(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        neg;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then check latency, result and pulse width.
    task automatic run_conv(input logic [15:0] bin, input logic [19:0] ebcd, input logic eneg, input string name);
        int k;
        @(negedge clk);
        bus.bin_in = bin;
        bus.start  = 1'b1;
        @(posedge clk);              // E0
        @(negedge clk);
        chk({name, " busy_after_trig"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (bus.valid) break;
        end
        chk({name, " latency"}, 32'(k), 32'd16);
        chk({name, " bcd"}, 32'(bus.bcd), 32'(ebcd));
        chk({name, " neg"}, 32'(bus.neg), 32'(eneg));
        @(negedge clk);
        chk({name, " valid_1cyc"}, 32'(bus.valid), 32'd0);
        chk({name, " busy_low"}, 32'(bus.busy), 32'd0);
        chk({name, " bcd_hold"}, 32'(bus.bcd), 32'(ebcd));
    endtask

    // Count valid pulses over a fixed window of cycles.
    task automatic count_valid(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.valid) pulses++;
        end
    endtask

    initial begin
        int p;
        n_chk = 0;
        n_err = 0;

`ifdef SIGNED_IN_EN
        vt[0] = '{16'h0000, 20'h00000, 1'b0};
        vt[1] = '{16'hFFFF, 20'h00001, 1'b1};
        vt[2] = '{16'd1234, 20'h01234, 1'b0};
        vt[3] = '{16'd9999, 20'h09999, 1'b0};
        vt[4] = '{16'h8000, 20'h32768, 1'b1};
        vt[5] = '{16'h0001, 20'h00001, 1'b0};
        vt[6] = '{16'hC000, 20'h16384, 1'b1};
        vt[7] = '{16'h00E1, 20'h00225, 1'b0};
`else
        vt[0] = '{16'h0000, 20'h00000, 1'b0};
        vt[1] = '{16'hFFFF, 20'h65535, 1'b0};
        vt[2] = '{16'd1234, 20'h01234, 1'b0};
        vt[3] = '{16'd9999, 20'h09999, 1'b0};
        vt[4] = '{16'h8000, 20'h32768, 1'b0};
        vt[5] = '{16'h0001, 20'h00001, 1'b0};
        vt[6] = '{16'hC000, 20'h49152, 1'b0};
        vt[7] = '{16'h00E1, 20'h00225, 1'b0};
`endif

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst valid", 32'(bus.valid), 32'd0);
        chk("rst bcd", 32'(bus.bcd), 32'd0);
        chk("rst neg", 32'(bus.neg), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_conv(vt[i].bin, vt[i].bcd, vt[i].neg, $sformatf("vec%0d", i));

        // Start held high for 40 cycles triggers exactly once.
        @(negedge clk);
        bus.bin_in = 16'd100;
        @(negedge clk);
        bus.bin_in = 16'h00E1;
        bus.start  = 1'b1;
        count_valid(40, p);
        chk("held pulses", 32'(p), 32'd1);
        chk("held bcd", 32'(bus.bcd), 32'h00225);
        bus.start = 1'b0;
        count_valid(10, p);
        chk("held no_extra", 32'(p), 32'd0);
        chk("held bcd_stable", 32'(bus.bcd), 32'h00225);

        // Retrigger and bin_in change during iteration are ignored.
        @(negedge clk);
        bus.bin_in = 16'd1234;
        bus.start  = 1'b1;
        @(posedge clk);              // E0
        repeat (5) @(posedge clk);   // iteration 5
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bin_in = 16'd9999;
        @(negedge clk);
        bus.start  = 1'b1;
        count_valid(30, p);
        chk("retrig pulses", 32'(p), 32'd1);
        chk("retrig bcd", 32'(bus.bcd), 32'h01234);
        bus.start = 1'b0;
        count_valid(25, p);
        chk("retrig no_second", 32'(p), 32'd0);

        // Reset at iteration 8 aborts with no pulse.
        @(negedge clk);
        bus.bin_in = 16'd4321;
        bus.start  = 1'b1;
        @(posedge clk);              // E0
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(posedge clk);   // E8
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort valid", 32'(bus.valid), 32'd0);
        chk("abort bcd", 32'(bus.bcd), 32'd0);
        rst = 1'b0;
        count_valid(20, p);
        chk("abort no_pulse", 32'(p), 32'd0);
        run_conv(16'd999, 20'h00999, 1'b0, "after_abort");

        // Start already high when reset releases gives one conversion.
        @(negedge clk);
        rst        = 1'b1;
        bus.bin_in = 16'd42;
        bus.start  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_valid(40, p);
        chk("start_at_rst pulses", 32'(p), 32'd1);
        chk("start_at_rst bcd", 32'(bus.bcd), 32'h00042);
        bus.start = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Downstream consumer of the shift-add multiplier.
- Takes the DW_2-bit `product` when the multiplier's `done` rises and converts it to packed BCD with a sequential double-dabble (shift-and-add-3) engine, one bit per clock.
- Feeds the seven-segment / display formatting logic.
- Holds the last result stable until the next conversion completes.

Parameters:
- DW_2, 16: width of the binary input (multiplier product width).
- NDIG, 5: number of BCD digits in the output. Must satisfy NDIG >= ceil(DW_2*log10(2)); 5 covers 16-bit unsigned. Not checked in RTL.
- CNTW, $clog2(DW_2)+1: iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  conversion request, level; connect to multiplier `done`
- bin_in  input  DW_2  binary value; connect to multiplier `product`
- busy  output  1  high while a conversion is in progress
- valid  output  1  one-cycle pulse when `bcd`/`neg` update
- bcd  output  4*NDIG  packed BCD result; digit 0 in bits [3:0]
- neg  output  1  sign of result (see Optional Feature)

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, valid=0, bcd=0, neg=0; internal shift/scratch registers=0; iteration counter=0; start_d (registered previous start)=0.
- Start detection: trigger = start & ~start_d. start_d updates every cycle in every state. A level held high triggers once only.
- Because start_d resets to 0, start already high when rst deasserts produces one conversion.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: busy=0. On trigger, capture bin_in into the shift register, clear the BCD scratch, clear the counter, go to SHIFT. busy=1 from the next cycle.
- SHIFT, one iteration per cycle:
  - Every scratch digit >= 5 gets +3, combinationally.
  - {scratch, shreg} then shifts left one bit; the shreg MSB enters the scratch LSB.
  - Counter increments. After the DW_2-th iteration go to DONE, loading bcd <= final scratch and valid <= 1 on that same edge.
- DONE: valid=1 for exactly this one cycle, busy=1. Next edge: go to IDLE, valid <= 0.
- Latency: edge sampling the trigger = E0. Iterations occur on E1..EDW_2. valid is high between EDW_2 and EDW_2+1 (16 cycles for the default).
- Triggers arriving in SHIFT or DONE are ignored, with no queueing. bin_in changes after capture have no effect.
- bcd and neg hold their value between conversions and change only on the edge that raises valid.
- Reset mid-conversion: abort immediately to the reset state; no valid pulse.
- Arithmetic: add-3 is applied per 4-bit digit, never as a carry across digits. The scratch register is 4*NDIG bits, and bits shifted out of the top are discarded.

Optional Feature:
- Macro: SIGNED_IN_EN.
- Defined:
  - bin_in is two's complement.
  - On capture, the magnitude (bin_in[DW_2-1] ? -bin_in : bin_in, computed in DW_2+1 bits so -2^(DW_2-1) is exact) is loaded into the shift register.
  - The sign bit is held internally and presented on `neg` together with `bcd` at the valid edge.
  - Conversion runs DW_2 iterations; latency is unchanged.
- Not defined:
  - bin_in is unsigned.
  - `neg` is constant 0; the port remains present.

Test Plan:
1. rst for 2 cycles, then bin_in=16'd0, start 0->1 -> busy=1 next cycle; valid pulses once 16 cycles after the trigger edge; bcd=20'h00000.
2. bin_in=16'd65535, start pulse -> bcd=20'h65535, valid high exactly 1 cycle, busy low the cycle after.
3. Chained with the multiplier: 15*15, start=done held high for 40 cycles, bin_in=16'h00E1 -> exactly one valid pulse; bcd=20'h00225; bcd stable for the rest of the run.
4. bin_in=16'd1234, trigger; at iteration 5, drop start, change bin_in to 16'd9999, re-raise start -> single valid with bcd=20'h01234; no second conversion.
5. bin_in=16'd4321, trigger; rst=1 at iteration 8 -> next cycle busy=0, valid=0, bcd=0, and no pulse for the aborted run; release rst with start low, then trigger with bin_in=16'd999 -> bcd=20'h00999.
6. With SIGNED_IN_EN: bin_in=16'hFFFF -> neg=1, bcd=20'h00001; bin_in=16'h8000 -> neg=1, bcd=20'h32768. Without the macro: bin_in=16'h8000 -> neg=0, bcd=20'h32768.
